conv_engine: RTL and testbench



---
 rtl/conv_engine_pkg.sv | 51 +++++
 rtl/conv_engine_if.sv | 28 ++
 rtl/conv_dot3x3.sv | 35 +++
 rtl/conv_engine.sv | 104 ++++++++++
 tb/tb_conv_engine.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_engine_pkg
// Description : Shared widths, DMA word field positions and register select
//               codes for the 3x3 convolution engine.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_engine_pkg;

  // Element and accumulator widths
  localparam int ELEM_W = 8;
  localparam int ACC_W  = 32;
  localparam int ROW_W  = 3 * ELEM_W;
  localparam int VEC_W  = 9 * ELEM_W;
  // Nine 16-bit products stay within +/-147456, which fits in 20 signed bits
  localparam int SUM_W  = 20;

  // DMA write word layout
  localparam int DMA_DATA_MSB = 31;
  localparam int DMA_DATA_LSB = 8;
  localparam int DMA_WE_BIT   = 7;
  localparam int DMA_SEL_MSB  = 2;
  localparam int DMA_SEL_LSB  = 0;

  // Register select codes; 6 and 7 are decoded as no-ops
  typedef enum logic [2:0] {
    SEL_P0 = 3'd0,
    SEL_P1 = 3'd1,
    SEL_P2 = 3'd2,
    SEL_K0 = 3'd3,
    SEL_K1 = 3'd4,
    SEL_K2 = 3'd5
  } sel_e;

  typedef struct packed {
    logic [ROW_W-1:0] data;
    logic             we;
    logic [2:0]       sel;
  } dma_wr_t;

  // Split a raw DMA word into its data, write-enable and select fields
  function automatic dma_wr_t decode_dma(input logic [31:0] word);
    dma_wr_t w;
    w.data = word[DMA_DATA_MSB:DMA_DATA_LSB];
    w.we   = word[DMA_WE_BIT];
    w.sel  = word[DMA_SEL_MSB:DMA_SEL_LSB];
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_engine_if
// Description : DMA write port, accumulator controls and result of the
//               convolution engine. The master drives, the slave is the engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_engine_if;
  logic [31:0] DMAport;
  logic        acc_enable;
  logic        acc_clear;
  logic [31:0] result;

  modport master (
    output DMAport,
    output acc_enable,
    output acc_clear,
    input  result
  );

  modport slave (
    input  DMAport,
    input  acc_enable,
    input  acc_clear,
    output result
  );
endinterface
`default_nettype wire

// File: rtl/conv_dot3x3.sv
`default_nettype none
// ============================================================================
// Module      : conv_dot3x3
// Description : Combinational 9-tap signed int8 dot product. Element 0 sits in
//               the top byte of each 72-bit vector, element 8 in the bottom.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_dot3x3
  import conv_engine_pkg::*;
(
  input  logic [VEC_W-1:0]        pix_vec,
  input  logic [VEC_W-1:0]        ker_vec,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [2*ELEM_W-1:0] prod [9];
  logic signed [SUM_W-1:0]    tot;

  // One signed 8x8 multiplier per tap
  for (genvar i = 0; i < 9; i++) begin : g_tap
    assign prod[i] = $signed(pix_vec[VEC_W-1-ELEM_W*i -: ELEM_W])
                   * $signed(ker_vec[VEC_W-1-ELEM_W*i -: ELEM_W]);
  end

  // Adder tree at 20 bits, then sign-extend to accumulator width
  always_comb begin
    tot = '0;
    for (int i = 0; i < 9; i++) begin
      tot = tot + SUM_W'(prod[i]);
    end
    sum = ACC_W'(tot);
  end

endmodule
`default_nettype wire

// File: rtl/conv_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv_engine
// Description : 3x3 signed int8 convolution engine. Six 24-bit row registers
//               (pixels P0..P2, kernel K0..K2) are loaded through a 32-bit
//               DMA word; the 9-tap dot product is added into a 32-bit
//               accumulator on every enabled clock.
//               Build option CONV_ENGINE_SAT_EN: saturate the accumulator add
//               instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_engine
  import conv_engine_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  conv_engine_if.slave  bus
);

  logic [ROW_W-1:0]        pix_q [3];
  logic [ROW_W-1:0]        pix_d [3];
  logic [ROW_W-1:0]        ker_q [3];
  logic [ROW_W-1:0]        ker_d [3];
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] dot_sum;
  dma_wr_t                 wr;
  logic                    unused_rsvd;

  // Reserved DMA bits carry no meaning
  assign unused_rsvd = ^bus.DMAport[6:3];

  assign wr = decode_dma(bus.DMAport);

  // Write decode: selected row takes the data byte triple, codes 6/7 ignored
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      pix_d[r] = pix_q[r];
      ker_d[r] = ker_q[r];
    end
    if (wr.we) begin
      case (sel_e'(wr.sel))
        SEL_P0:  pix_d[0] = wr.data;
        SEL_P1:  pix_d[1] = wr.data;
        SEL_P2:  pix_d[2] = wr.data;
        SEL_K0:  ker_d[0] = wr.data;
        SEL_K1:  ker_d[1] = wr.data;
        SEL_K2:  ker_d[2] = wr.data;
        default: ;
      endcase
    end
  end

  // Dot product always sees the registers as they stood before the edge
  conv_dot3x3 u_dot (
    .pix_vec ({pix_q[0], pix_q[1], pix_q[2]}),
    .ker_vec ({ker_q[0], ker_q[1], ker_q[2]}),
    .sum     (dot_sum)
  );

`ifdef CONV_ENGINE_SAT_EN
  logic signed [ACC_W:0] acc_wide;
  assign acc_wide = {acc_q[ACC_W-1], acc_q} + {dot_sum[ACC_W-1], dot_sum};
`endif

  // Accumulator next state: clear beats enable, otherwise hold
  always_comb begin
    acc_d = acc_q;
    if (bus.acc_clear) begin
      acc_d = '0;
    end else if (bus.acc_enable) begin
`ifdef CONV_ENGINE_SAT_EN
      if (acc_wide[ACC_W] != acc_wide[ACC_W-1]) begin
        acc_d = acc_wide[ACC_W] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
      end else begin
        acc_d = acc_wide[ACC_W-1:0];
      end
`else
      acc_d = acc_q + dot_sum;
`endif
    end
  end

  // State registers; low reset clears everything immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        pix_q[r] <= '0;
        ker_q[r] <= '0;
      end
      acc_q <= '0;
    end else begin
      for (int r = 0; r < 3; r++) begin
        pix_q[r] <= pix_d[r];
        ker_q[r] <= ker_d[r];
      end
      acc_q <= acc_d;
    end
  end

  assign bus.result = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_engine
// Description : Self-checking bench for conv_engine. A behavioural model of
//               the row registers and accumulator produces expected results,
//               which are queued and compared when the DUT output is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_engine;
  import conv_engine_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  conv_engine_if bus ();

  conv_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  // Model state
  logic [23:0] mp [3];
  logic [23:0] mk [3];
  longint      m_acc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)",
               tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  function automatic longint model_dot();
    longint s = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        byte pa;
        byte kb;
        pa = mp[r][23-8*c -: 8];
        kb = mk[r][23-8*c -: 8];
        s += longint'(pa) * longint'(kb);
      end
    end
    return s;
  endfunction

  function automatic longint model_add(input longint a, input longint b);
    longint      s;
    logic [31:0] t;
    s = a + b;
`ifdef CONV_ENGINE_SAT_EN
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s;
`else
    t = s[31:0];
    return longint'($signed(t));
`endif
  endfunction

  // One clock of stimulus; model updates with pre-edge register contents
  task automatic drive(input logic [2:0] sel, input logic [23:0] data, input logic we,
                       input logic en, input logic clr);
    bus.DMAport    = {data, we, 4'b0000, sel};
    bus.acc_enable = en;
    bus.acc_clear  = clr;
    if (clr)     m_acc = 0;
    else if (en) m_acc = model_add(m_acc, model_dot());
    if (we) begin
      case (sel)
        3'd0: mp[0] = data;
        3'd1: mp[1] = data;
        3'd2: mp[2] = data;
        3'd3: mk[0] = data;
        3'd4: mk[1] = data;
        3'd5: mk[2] = data;
        default: ;
      endcase
    end
    @(negedge clk);
    bus.DMAport    = '0;
    bus.acc_enable = 1'b0;
    bus.acc_clear  = 1'b0;
  endtask

  task automatic load(input logic [23:0] p0, p1, p2, k0, k1, k2);
    drive(3'd0, p0, 1'b1, 1'b0, 1'b0);
    drive(3'd1, p1, 1'b1, 1'b0, 1'b0);
    drive(3'd2, p2, 1'b1, 1'b0, 1'b0);
    drive(3'd3, k0, 1'b1, 1'b0, 1'b0);
    drive(3'd4, k1, 1'b1, 1'b0, 1'b0);
    drive(3'd5, k2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic accum(input logic en, input logic clr);
    drive(3'd0, 24'h0, 1'b0, en, clr);
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  // Compare the DUT output against the oldest queued expectation
  task automatic pop_check();
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      check_val(tag_q.pop_front(), bus.result, exp_q.pop_front());
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] v);
    push_exp(tag, v);
    pop_check();
  endtask

  initial begin
    bus.DMAport    = '0;
    bus.acc_enable = 1'b0;
    bus.acc_clear  = 1'b0;
    for (int r = 0; r < 3; r++) begin
      mp[r] = '0;
      mk[r] = '0;
    end
    m_acc = 0;

    repeat (2) @(negedge clk);
    expect_now("reset_state", 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Identity kernel
    load(24'h0A0A0A, 24'h0A0A0A, 24'h0A0A0A, 24'h000000, 24'h000100, 24'h000000);
    accum(1'b0, 1'b1);
    accum(1'b1, 1'b0);
    expect_now("identity", 32'd10);

    // Ramp with all-ones kernel
    load(24'h010203, 24'h040506, 24'h070809, 24'h010101, 24'h010101, 24'h010101);
    accum(1'b0, 1'b1);
    accum(1'b1, 1'b0);
    expect_now("ramp", 32'd45);

    // Write with enable low must not change P0
    drive(3'd0, 24'h7F7F7F, 1'b0, 1'b0, 1'b0);
    accum(1'b0, 1'b1);
    accum(1'b1, 1'b0);
    expect_now("we_low_ignored", 32'd45);

    // Select codes 6 and 7 are no-ops
    drive(3'd6, 24'h7F7F7F, 1'b1, 1'b0, 1'b0);
    drive(3'd7, 24'h7F7F7F, 1'b1, 1'b0, 1'b0);
    accum(1'b0, 1'b1);
    accum(1'b1, 1'b0);
    expect_now("sel67_noop", 32'd45);

    // Write on the same edge as accumulation uses the old P0
    accum(1'b0, 1'b1);
    drive(3'd0, 24'h000000, 1'b1, 1'b1, 1'b0);
    expect_now("same_edge_old", 32'd45);
    accum(1'b1, 1'b0);
    expect_now("same_edge_new", 32'd84);

    // Signed handling
    load(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    accum(1'b0, 1'b1);
    accum(1'b1, 1'b0);
    expect_now("neg_times_neg", 32'd9);
    load(24'h7F7F7F, 24'h7F7F7F, 24'h7F7F7F, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    accum(1'b0, 1'b1);
    accum(1'b1, 1'b0);
    expect_now("pos_times_neg", -32'sd1143);

    // Accumulate twice, then clear with enable also high
    load(24'h0A0A0A, 24'h0A0A0A, 24'h0A0A0A, 24'h010101, 24'h010101, 24'h010101);
    accum(1'b0, 1'b1);
    accum(1'b1, 1'b0);
    expect_now("accum_1", 32'd90);
    accum(1'b1, 1'b0);
    expect_now("accum_2", 32'd180);
    accum(1'b0, 1'b0);
    expect_now("hold", 32'd180);
    accum(1'b1, 1'b1);
    expect_now("clear_wins", 32'd0);

    // Sobel kernel on a flat image
    load(24'h646464, 24'h646464, 24'h646464, 24'hFF0001, 24'hFE0002, 24'hFF0001);
    accum(1'b0, 1'b1);
    accum(1'b1, 1'b0);
    expect_now("sobel_flat", 32'd0);

    // Random patterns against the model
    for (int t = 0; t < 4; t++) begin
      load(24'($urandom), 24'($urandom), 24'($urandom),
           24'($urandom), 24'($urandom), 24'($urandom));
      accum(1'b0, 1'b1);
      for (int c = 0; c < 3; c++) accum(1'b1, 1'b0);
      expect_now($sformatf("random_%0d", t), 32'(m_acc));
    end

    // Asynchronous reset in the middle of an accumulation
    load(24'h0A0A0A, 24'h0A0A0A, 24'h0A0A0A, 24'h010101, 24'h010101, 24'h010101);
    accum(1'b0, 1'b1);
    accum(1'b1, 1'b0);
    bus.acc_enable = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      mp[r] = '0;
      mk[r] = '0;
    end
    m_acc = 0;
    #1;
    expect_now("async_reset", 32'd0);
    @(negedge clk);
    bus.acc_enable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    // Kernels only: pixels must have been cleared by reset
    drive(3'd3, 24'h010101, 1'b1, 1'b0, 1'b0);
    drive(3'd4, 24'h010101, 1'b1, 1'b0, 1'b0);
    drive(3'd5, 24'h010101, 1'b1, 1'b0, 1'b0);
    accum(1'b1, 1'b0);
    expect_now("regs_after_reset", 32'd0);

    // Long run past the 32-bit limit: clamps or wraps depending on build
    load(24'h7F7F7F, 24'h7F7F7F, 24'h7F7F7F, 24'h7F7F7F, 24'h7F7F7F, 24'h7F7F7F);
    accum(1'b0, 1'b1);
    for (int c = 0; c < 14800; c++) accum(1'b1, 1'b0);
`ifdef CONV_ENGINE_SAT_EN
    expect_now("saturate_max", 32'h7FFF_FFFF);
`else
    expect_now("wrap", -32'sd2146584496);
`endif
    expect_now("overflow_model", 32'(m_acc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
